// File: rtl/arbiter_rr2.sv
// Two-requester round-robin arbiter with hold-time preemption and per-requester grant counters.
// Grants are registered; a grant may hand over directly to the other requester with no idle cycle.
module arbiter_rr2 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              hold_sat;
    logic              entry;

    assign hold_sat = (hold_q == HOLD_MAX);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    // last_q == 1 means requester 1 was served last, so 0 wins the tie
                    state_d = last_q ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!req0) begin
                    state_d = req1 ? GNT1 : IDLE;
                end else if (req1 && hold_sat) begin
                    state_d = GNT1;
                end
            end
            GNT1: begin
                if (!req1) begin
                    state_d = req0 ? GNT0 : IDLE;
                end else if (req0 && hold_sat) begin
                    state_d = GNT0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        entry  = (state_d != state_q) && (state_d != IDLE);
        last_d = last_q;
        hold_d = hold_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        gnt0_d = (state_d == GNT0);
        gnt1_d = (state_d == GNT1);

        if (state_d == IDLE) begin
            hold_d = '0;
        end else if (entry) begin
            hold_d = HOLD_W'(1);
        end else if (!hold_sat) begin
            hold_d = hold_q + HOLD_W'(1);
        end

        if (entry) begin
            last_d = (state_d == GNT1);
            if (state_d == GNT0) begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end else begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;

endmodule

// File: doc/arbiter_rr2.md
# arbiter_rr2

Two-requester synchronous arbiter: the responder side of the `req0`/`req1` → `gnt0`/`gnt1` handshake that the arbiter benches drive and check. It grants one requester at a time, keeps a grant while the request is held, and rotates priority round-robin. It preempts a long-held grant after `MAX_HOLD` cycles when the other side is waiting. Per-requester grant counters are provided for scoreboard cross-checking.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while the other requester is waiting; legal range 2..255.
- `CNT_W`, default 8: width of each grant counter.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `req0`  input  1  request from requester 0; level, held until served.
- `req1`  input  1  request from requester 1.
- `gnt0`  output  1  grant to requester 0; registered.
- `gnt1`  output  1  grant to requester 1; registered.
- `gnt_cnt0`  output  CNT_W  number of grants issued to requester 0, modulo 2^CNT_W.
- `gnt_cnt1`  output  CNT_W  number of grants issued to requester 1, modulo 2^CNT_W.

## Operation
- State machine: IDLE, GNT0, GNT1. `gnt0` = (state==GNT0) and `gnt1` = (state==GNT1), both driven from registers.
- `last` flag records the last-served requester. On reset `last`=1, so requester 0 wins the first tie.
- `hold` counter, width clog2(MAX_HOLD+1):
  - set to 1 on entry to GNT0/GNT1;
  - +1 each cycle the state is held;
  - saturates at MAX_HOLD.
- IDLE transitions:
  - `req0 & req1` → grant the requester ≠ `last`.
  - Only `req0` → GNT0.
  - Only `req1` → GNT1.
  - Neither → stay in IDLE.
- GNT0 transitions (GNT1 is symmetric):
  - `!req0 & req1` → GNT1 (direct handover, no idle cycle).
  - `!req0 & !req1` → IDLE.
  - `req0 & req1 & hold==MAX_HOLD` → GNT1 (preemption).
  - Otherwise stay in GNT0.
- `last` updates to the granted index on every entry to a GNT state.
- `gnt_cntN` increments by 1 on each entry to GNTN, i.e. on each `gntN` rising edge and on each direct handover into N. Counters wrap 2^CNT_W−1 → 0 with no flag.
- Mutual exclusion: `gnt0 & gnt1` is never 1 in any cycle, including during handover.
- A request dropped without ever being granted is simply forgotten. No request is latched.

## Timing
- Reset (`reset`=0 at an edge): after that edge, `gnt0`=`gnt1`=0, state=IDLE, `hold`=0, `last`=1, `gnt_cnt0`=`gnt_cnt1`=0. Reset overrides all other activity, including a grant in progress.
- Grant latency: a request sampled high at edge k (arbiter IDLE) gives the grant high after edge k, visible in cycle k+1. That is 1 cycle.
- Release latency: `reqN` sampled low at edge k gives `gntN` low after edge k.
- Handover: on the edge where `gnt0` falls, `gnt1` rises. Zero gap, zero overlap.
- Preemption: with both requests continuously high, each grant lasts exactly MAX_HOLD cycles and then alternates.
- If the other request arrives after `hold` has saturated, the switch happens at the first edge where it is sampled high.
- First cycle after reset deasserts: requests are sampled normally, with no dead cycle.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `req0`=`req1`=1 → `gnt0`=`gnt1`=0 and both counters 0 throughout. On release, `gnt0`=1 one cycle later.
- Single requester: `req0`=1 for 5 cycles then 0 → `gnt0` high for exactly 5 cycles, lagging 1 cycle; `gnt_cnt0`=1; `gnt1` stays 0.
- Tie from IDLE after reset: `req0`=`req1`=1 in the same cycle → GNT0 first. Drop `req0` after 3 grant cycles → `gnt1` rises on the same edge `gnt0` falls; `gnt_cnt1`=1.
- Preemption, MAX_HOLD=8, both requests held 40 cycles → grants alternate 0,1,0,1,0, each exactly 8 cycles. Ends with `gnt_cnt0`=3, `gnt_cnt1`=2.
- Reset mid-grant: assert reset during cycle 4 of a GNT1 → `gnt1`=0 after that edge, counters 0. Tie after release → GNT0.
- Counter wrap, CNT_W=8: issue 257 separate `req0` pulses, each 2 cycles high and 2 low → `gnt_cnt0`=1. The random checker confirms no `gnt0&gnt1` in any cycle.
